// File: rtl/simd_pe_if.sv
// Setup-instruction, memory read/write and completion signals of simd_pe.
// slave = the processing element side, master = the host/memory side.
interface simd_pe_if #(
   parameter int LANES  = 4,
   parameter int LANE_W = 32,
   parameter int ADDR_W = 32
);
   localparam int DW = LANES * LANE_W;

   logic              i_en;
   logic              i_valid;
   logic [1:0]        i_opcode;
   logic [ADDR_W-1:0] i_info;
   logic              o_ack;

   logic              o_req_rd;
   logic [ADDR_W-1:0] o_rd_addr;
   logic              i_grant_rd;
   logic              i_rd_valid;
   logic [DW-1:0]     i_rd_data;

   logic              o_req_wr;
   logic [ADDR_W-1:0] o_wr_addr;
   logic [DW-1:0]     o_wr_data;
   logic              i_grant_wr;
   logic              i_wr_done;

   logic              o_busy;
   logic              o_finish;
   logic              i_finish_ack;

   modport slave (
      input  i_en, i_valid, i_opcode, i_info,
      input  i_grant_rd, i_rd_valid, i_rd_data,
      input  i_grant_wr, i_wr_done, i_finish_ack,
      output o_ack, o_req_rd, o_rd_addr, o_req_wr, o_wr_addr, o_wr_data,
      output o_busy, o_finish
   );

   modport master (
      output i_en, i_valid, i_opcode, i_info,
      output i_grant_rd, i_rd_valid, i_rd_data,
      output i_grant_wr, i_wr_done, i_finish_ack,
      input  o_ack, o_req_rd, o_rd_addr, o_req_wr, o_wr_addr, o_wr_data,
      input  o_busy, o_finish
   );
endinterface

// File: rtl/simd_pe.sv
// SIMD lane processor: loads two vectors per beat, applies a lane op, writes back.
// Define SIMD_PE_SAT_EN for signed saturating add/sub/mul instead of wrap-around.
//
// state     | meaning
// IDLE      | waiting for i_en
// LD1       | waiting for LD of source/destination address addr_0
// LD2       | waiting for LD of second source address addr_1
// SET_COUNT | waiting for INFO carrying the element count
// SET_OP    | waiting for OP carrying the lane operation
// FETCH1    | reading vector at addr_0 into reg0
// FETCH2    | reading vector at addr_1 into reg1
// EXEC      | computing lane results
// WRITE     | writing result to addr_0
// FINISHED  | holding o_finish until i_finish_ack
module simd_pe #(
   parameter int LANES  = 4,
   parameter int LANE_W = 32,
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input logic      i_clk,
   input logic      i_rst,
   simd_pe_if.slave bus
);
   localparam int DW = LANES * LANE_W;
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(LANES * LANE_W / 8);
   localparam logic [1:0] OPC_LD   = 2'd0;
   localparam logic [1:0] OPC_INFO = 2'd1;
   localparam logic [1:0] OPC_OP   = 2'd2;

   typedef enum logic [3:0] {
      IDLE, LD1, LD2, SET_COUNT, SET_OP, FETCH1, FETCH2, EXEC, WRITE, FINISHED
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
   logic [CNT_W-1:0]  count_q, count_d, cnt_next;
   logic [1:0]        op_q, op_d;
   logic [DW-1:0]     reg0_q, reg0_d, reg1_q, reg1_d, res_q, res_d;
   logic              ack_q, ack_d;
   logic              last_beat;

   function automatic logic [LANE_W-1:0] lane_alu(input logic [1:0] op,
                                                  input logic [LANE_W-1:0] a,
                                                  input logic [LANE_W-1:0] b);
`ifdef SIMD_PE_SAT_EN
      logic signed [2*LANE_W-1:0] wa, wb, r, hi, lo;
      wa = {{LANE_W{a[LANE_W-1]}}, a};
      wb = {{LANE_W{b[LANE_W-1]}}, b};
      hi = {{(LANE_W+1){1'b0}}, {(LANE_W-1){1'b1}}};
      lo = ~hi;
      case (op)
         2'd0:    r = wa + wb;
         2'd1:    r = wa * wb;
         2'd2:    r = wa - wb;
         default: r = wa;
      endcase
      if (r > hi)      r = hi;
      else if (r < lo) r = lo;
      return r[LANE_W-1:0];
`else
      logic [LANE_W-1:0] r;
      case (op)
         2'd0:    r = a + b;
         2'd1:    r = a * b;
         2'd2:    r = a - b;
         default: r = a;
      endcase
      return r;
`endif
   endfunction

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         addr0_q <= '0;
         addr1_q <= '0;
         count_q <= '0;
         op_q    <= '0;
         reg0_q  <= '0;
         reg1_q  <= '0;
         res_q   <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr0_q <= addr0_d;
         addr1_q <= addr1_d;
         count_q <= count_d;
         op_q    <= op_d;
         reg0_q  <= reg0_d;
         reg1_q  <= reg1_d;
         res_q   <= res_d;
         ack_q   <= ack_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr0_d   = addr0_q;
      addr1_d   = addr1_q;
      count_d   = count_q;
      op_d      = op_q;
      reg0_d    = reg0_q;
      reg1_d    = reg1_q;
      res_d     = res_q;
      ack_d     = 1'b0;
      last_beat = count_q < CNT_W'(LANES);
      cnt_next  = last_beat ? '0 : count_q - CNT_W'(LANES);
      case (state_q)
         IDLE: if (bus.i_en) state_d = LD1;
         LD1: if (bus.i_valid && bus.i_opcode == OPC_LD) begin
            addr0_d = bus.i_info;
            ack_d   = 1'b1;
            state_d = LD2;
         end
         LD2: if (bus.i_valid && bus.i_opcode == OPC_LD) begin
            addr1_d = bus.i_info;
            ack_d   = 1'b1;
            state_d = SET_COUNT;
         end
         SET_COUNT: if (bus.i_valid && bus.i_opcode == OPC_INFO) begin
            count_d = bus.i_info[CNT_W-1:0];
            ack_d   = 1'b1;
            state_d = SET_OP;
         end
         SET_OP: if (bus.i_valid && bus.i_opcode == OPC_OP) begin
            op_d    = bus.i_info[1:0];
            ack_d   = 1'b1;
            state_d = (count_q == '0) ? FINISHED : FETCH1;
         end
         FETCH1: if (bus.i_grant_rd && bus.i_rd_valid) begin
            reg0_d  = bus.i_rd_data;
            state_d = FETCH2;
         end
         FETCH2: if (bus.i_grant_rd && bus.i_rd_valid) begin
            reg1_d  = bus.i_rd_data;
            state_d = EXEC;
         end
         EXEC: begin
            // Lanes past the remaining count pass reg0 through on the last beat
            for (int i = 0; i < LANES; i++) begin
               res_d[i*LANE_W +: LANE_W] = (CNT_W'(i) < count_q) ?
                  lane_alu(op_q, reg0_q[i*LANE_W +: LANE_W], reg1_q[i*LANE_W +: LANE_W]) :
                  reg0_q[i*LANE_W +: LANE_W];
            end
            state_d = WRITE;
         end
         WRITE: if (bus.i_grant_wr && bus.i_wr_done) begin
            addr0_d = addr0_q + ADDR_STEP;
            addr1_d = addr1_q + ADDR_STEP;
            count_d = cnt_next;
            state_d = (cnt_next == '0) ? FINISHED : FETCH1;
         end
         FINISHED: if (bus.i_finish_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.o_ack     = ack_q;
   assign bus.o_req_rd  = (state_q == FETCH1) || (state_q == FETCH2);
   assign bus.o_rd_addr = (state_q == FETCH2) ? addr1_q : addr0_q;
   assign bus.o_req_wr  = (state_q == WRITE);
   assign bus.o_wr_addr = addr0_q;
   assign bus.o_wr_data = res_q;
   assign bus.o_busy    = (state_q != IDLE);
   assign bus.o_finish  = (state_q == FINISHED);
endmodule

// File: doc/simd_pe.md
SIMD_PE -- requirements
Module: simd_pe

Interface
REQ-001 SHALL have parameter LANES, default 4, number of SIMD lanes (1..16).
REQ-002 SHALL have parameter LANE_W, default 32, bits per lane; DW = LANES*LANE_W.
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL have parameter CNT_W, default 16, element-count width.
REQ-005 SHALL have port i_clk, input, 1 bit, the single clock, all logic on its rising edge.
REQ-006 SHALL have port i_rst, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port i_en, input, 1 bit, start setup from IDLE.
REQ-008 SHALL have ports i_valid (1 bit), i_opcode (2 bits: 0 LD, 1 INFO, 2 OP), i_info (ADDR_W bits), all inputs, setup instruction bus.
REQ-009 SHALL have port o_ack, output, 1 bit, one-cycle instruction-accept pulse.
REQ-010 SHALL have ports o_req_rd and o_rd_addr (outputs), and i_grant_rd, i_rd_valid, i_rd_data (inputs, DW bits), read channel.
REQ-011 SHALL have ports o_req_wr, o_wr_addr, o_wr_data (outputs, DW bits), and i_grant_wr, i_wr_done (inputs), write channel.
REQ-012 SHALL have ports o_busy, o_finish (outputs) and i_finish_ack (input), completion handshake.

Function
REQ-013 SHALL implement states IDLE, LD1, LD2, SET_COUNT, SET_OP, FETCH1, FETCH2, EXEC, WRITE, FINISHED.
REQ-014 SHALL move IDLE->LD1 when i_en=1.
REQ-015 SHALL in each setup state accept only the matching opcode with i_valid=1: LD1/LD2 LD (latch addr_0/addr_1), SET_COUNT INFO (latch count = i_info[CNT_W-1:0]), SET_OP OP (latch op = i_info[1:0]); other opcodes are ignored and o_ack stays 0.
REQ-016 SHALL pulse o_ack for exactly the cycle after each accepted instruction.
REQ-017 SHALL go SET_OP->FINISHED directly when count=0, else SET_OP->FETCH1.
REQ-018 SHALL hold o_req_rd=1 throughout FETCH1/FETCH2 with o_rd_addr = addr_0 / addr_1; data is captured on the first cycle with i_grant_rd=1 and i_rd_valid=1.
REQ-019 SHALL spend one cycle in EXEC registering lane results: op 0 add, 1 mul (low LANE_W bits), 2 sub (reg0-reg1), 3 pass reg0.
REQ-020 SHALL on the final beat (remaining count < LANES) output reg0 unchanged in lanes index >= remaining.
REQ-021 SHALL hold o_req_wr=1 in WRITE with o_wr_addr=addr_0 and stable o_wr_data until i_grant_wr=1 and i_wr_done=1 in the same cycle.
REQ-022 SHALL on write completion add LANES*LANE_W/8 to both addresses (modulo 2^ADDR_W), subtract min(LANES, remaining) from count, and go to FETCH1 if count>0, else FINISHED.
REQ-023 SHALL hold o_finish=1 in FINISHED until i_finish_ack=1, then return to IDLE.
REQ-024 SHALL drive o_busy=1 in every state except IDLE.
REQ-025 SHALL ignore i_en outside IDLE and all instruction inputs outside setup states.

Reset
REQ-026 SHALL on i_rst=1 enter IDLE and clear o_ack, o_req_rd, o_req_wr, o_busy, o_finish, addresses, count, op and data registers to 0, overriding any in-flight transaction in the same edge.

Configuration
REQ-027 SHALL when SIMD_PE_SAT_EN is defined perform signed saturating add/sub/mul per lane (clamp to [-2^(LANE_W-1), 2^(LANE_W-1)-1]); without it, wrap modulo 2^LANE_W.

Verification
REQ-028 SHALL cover: LANES=4, LANE_W=32, LD 0x100, LD 0x200, INFO 4, OP 0, lanes {1,2,3,4}+{10,20,30,40} -> one write to 0x100 of {11,22,33,44}, then o_finish=1.
REQ-029 SHALL cover: count=6, op 1 -> two writes at 0x100 and 0x110; second write lanes 2..3 equal reg0 lanes.
REQ-030 SHALL cover: INFO 0 -> FINISHED with no o_req_rd/o_req_wr asserted.
REQ-031 SHALL cover: i_grant_wr withheld 5 cycles -> o_wr_data/o_wr_addr stable, o_req_wr held.
REQ-032 SHALL cover: 0x7FFFFFFF+1 with op 0 -> 0x80000000 without macro, 0x7FFFFFFF with SIMD_PE_SAT_EN.
REQ-033 SHALL cover: i_rst asserted during FETCH2 -> next cycle IDLE, all outputs 0.
